// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side pointer and flag controller for an asynchronous FIFO. Everything
// here runs in the write clock domain.
//
// Ports:
//   clk               write-domain clock
//   rst               synchronous, active-high reset
//   wr_en             write request from the producer
//   rd_ptr_grey_sync  read Gray pointer, already synchronized into clk
//   ovf_clr           clears the sticky overflow flag
//   mem_we            RAM write enable (combinational: request and not full)
//   wr_addr           RAM write address (low bits of the binary write pointer)
//   wr_ptr_grey       registered Gray write pointer, to the read-side sync
//   full              FIFO full (registered, pessimistic)
//   almost_full       level >= AF_THRESH (registered)
//   wr_level          occupancy seen from the write side (registered)
//   overflow          sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
  parameter int PNTR      = 4,
  parameter int AF_THRESH = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [PNTR:0]   rd_ptr_grey_sync,
  input  logic            ovf_clr,
  output logic            mem_we,
  output logic [PNTR-1:0] wr_addr,
  output logic [PNTR:0]   wr_ptr_grey,
  output logic            full,
  output logic            almost_full,
  output logic [PNTR:0]   wr_level,
  output logic            overflow
);

  localparam logic [PNTR:0] AF_T = AF_THRESH[PNTR:0];

  logic [PNTR:0] r_wbin;
  logic [PNTR:0] r_wgray;
  logic          r_full;
  logic          r_af;
  logic [PNTR:0] r_level;
  logic          r_ovf;

  logic          w_accept;
  logic          w_ovf_set;
  logic [PNTR:0] w_wbin_next;
  logic [PNTR:0] w_wgray_next;
  logic [PNTR:0] w_rbin;
  logic [PNTR:0] w_diff;
  logic [PNTR:0] w_full_gray;
  logic          w_full_next;

  function automatic logic [PNTR:0] gray2bin(input logic [PNTR:0] g);
    logic [PNTR:0] b;
    b[PNTR] = g[PNTR];
    for (int i = PNTR - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Reset gates the RAM strobe so nothing is written while the pointers clear.
  assign w_accept     = wr_en & ~r_full & ~rst;
  assign w_ovf_set    = wr_en & r_full;
  assign w_wbin_next  = r_wbin + {{PNTR{1'b0}}, w_accept};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  assign w_rbin       = gray2bin(rd_ptr_grey_sync);
  assign w_diff       = w_wbin_next - w_rbin;

  // Full in Gray space: write pointer is one lap ahead, which in Gray code
  // means the two MSBs inverted and the remaining bits equal.
  assign w_full_gray  = {~rd_ptr_grey_sync[PNTR:PNTR-1], rd_ptr_grey_sync[PNTR-2:0]};
  assign w_full_next  = (w_wgray_next == w_full_gray);

  // ---- register stage: pointers and flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
      r_af    <= (w_diff >= AF_T);
      r_level <= w_diff;
      // set wins over a simultaneous clear
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign mem_we      = w_accept;
  assign wr_addr     = r_wbin[PNTR-1:0];
  assign wr_ptr_grey = r_wgray;
  assign full        = r_full;
  assign almost_full = r_af;
  assign wr_level    = r_level;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;

  localparam int PNTR      = 4;
  localparam int AF_THRESH = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic [PNTR:0]   rd_ptr_grey_sync = '0;
  logic            ovf_clr = 1'b0;
  logic            mem_we;
  logic [PNTR-1:0] wr_addr;
  logic [PNTR:0]   wr_ptr_grey;
  logic            full;
  logic            almost_full;
  logic [PNTR:0]   wr_level;
  logic            overflow;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_ctrl #(.PNTR(PNTR), .AF_THRESH(AF_THRESH)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .rd_ptr_grey_sync (rd_ptr_grey_sync),
    .ovf_clr          (ovf_clr),
    .mem_we           (mem_we),
    .wr_addr          (wr_addr),
    .wr_ptr_grey      (wr_ptr_grey),
    .full             (full),
    .almost_full      (almost_full),
    .wr_level         (wr_level),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; rd_ptr_grey_sync = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; rd_ptr_grey_sync = '0; ovf_clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (mem_we !== 1'b0) begin
        n_fail++; $display("FAIL reset_mem_we cycle=%0d got=%b exp=0", c, mem_we);
      end
      tick();
    end
    rst = 1'b0; wr_en = 1'b0;
    #1;
    n_checks++;
    if ({mem_we, wr_addr, wr_ptr_grey, full, almost_full, wr_level, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs we=%b addr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b exp=all0",
               mem_we, wr_addr, wr_ptr_grey, full, almost_full, wr_level, overflow);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      #1;
      n_checks++;
      if (mem_we !== 1'b1 || wr_addr !== 4'(i)) begin
        n_fail++; $display("FAIL fill_write i=%0d we=%b addr=%0d exp we=1 addr=%0d", i, mem_we, wr_addr, i);
      end
      tick();
    end
    n_checks++;
    if (full !== 1'b1 || wr_ptr_grey !== 5'b11000 || wr_level !== 5'd16) begin
      n_fail++; $display("FAIL fill_full full=%b gray=%b lvl=%0d exp full=1 gray=11000 lvl=16", full, wr_ptr_grey, wr_level);
    end
    wr_en = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL ovf_reject_we got=%b exp=0", mem_we);
    end
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || wr_ptr_grey !== 5'b11000 || full !== 1'b1 || wr_level !== 5'd16) begin
      n_fail++; $display("FAIL ovf_state ovf=%b gray=%b full=%b lvl=%0d exp ovf=1 gray=11000 full=1 lvl=16",
                         overflow, wr_ptr_grey, full, wr_level);
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    write_n(11);
    n_checks++;
    if (almost_full !== 1'b0 || wr_level !== 5'd11) begin
      n_fail++; $display("FAIL af_11 af=%b lvl=%0d exp af=0 lvl=11", almost_full, wr_level);
    end
    write_n(1);
    n_checks++;
    if (almost_full !== 1'b1 || wr_level !== 5'd12 || full !== 1'b0) begin
      n_fail++; $display("FAIL af_12 af=%b lvl=%0d full=%b exp af=1 lvl=12 full=0", almost_full, wr_level, full);
    end
  endtask

  task automatic test_drain_release();
    do_reset();
    write_n(16);
    rd_ptr_grey_sync = 5'b00110;
    tick();
    n_checks++;
    if (full !== 1'b0 || wr_level !== 5'd12 || almost_full !== 1'b1) begin
      n_fail++; $display("FAIL drain full=%b lvl=%0d af=%b exp full=0 lvl=12 af=1", full, wr_level, almost_full);
    end
    write_n(3);
    n_checks++;
    if (full !== 1'b0 || wr_level !== 5'd15) begin
      n_fail++; $display("FAIL refill_3 full=%b lvl=%0d exp full=0 lvl=15", full, wr_level);
    end
    write_n(1);
    n_checks++;
    if (full !== 1'b1 || wr_level !== 5'd16 || wr_ptr_grey !== 5'b11110) begin
      n_fail++; $display("FAIL refill_4 full=%b lvl=%0d gray=%b exp full=1 lvl=16 gray=11110", full, wr_level, wr_ptr_grey);
    end
  endtask

  task automatic test_wrap();
    logic [PNTR:0] b;
    logic [PNTR:0] bn;
    logic [PNTR:0] g_exp;
    int bad;
    do_reset();
    b = '0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      // read side sits exactly at the current write pointer
      rd_ptr_grey_sync = b ^ (b >> 1);
      wr_en = 1'b1;
      tick();
      bn = b + 5'd1;
      g_exp = bn ^ (bn >> 1);
      if (full !== 1'b0 || wr_level !== 5'd1 || wr_ptr_grey !== g_exp) begin
        bad++;
        $display("FAIL wrap_step i=%0d full=%b lvl=%0d gray=%b exp full=0 lvl=1 gray=%b", i, full, wr_level, wr_ptr_grey, g_exp);
      end
      if (b == 5'd31) begin
        n_checks++;
        if (wr_ptr_grey !== 5'b00000 || wr_addr !== 4'd0) begin
          n_fail++; $display("FAIL wrap_rollover gray=%b addr=%0d exp gray=00000 addr=0", wr_ptr_grey, wr_addr);
        end
      end
      b = bn;
    end
    wr_en = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL wrap_sequence bad_steps=%0d exp=0", bad);
    end
  endtask

  task automatic test_edge_events();
    do_reset();
    write_n(16);
    wr_en = 1'b1; ovf_clr = 1'b1;
    tick();
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set_beats_clr got=%b exp=1", overflow);
    end
    wr_en = 1'b0; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr got=%b exp=0", overflow);
    end
    do_reset();
    write_n(7);
    n_checks++;
    if (wr_level !== 5'd7) begin
      n_fail++; $display("FAIL midburst_level got=%0d exp=7", wr_level);
    end
    wr_en = 1'b1; rst = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL midburst_rst_we got=%b exp=0", mem_we);
    end
    tick();
    n_checks++;
    if ({wr_addr, wr_ptr_grey, full, almost_full, wr_level, overflow} !== '0) begin
      n_fail++;
      $display("FAIL midburst_rst addr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b exp=all0",
               wr_addr, wr_ptr_grey, full, almost_full, wr_level, overflow);
    end
    rst = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_fill_overflow();
    test_almost_full();
    test_drain_release();
    test_wrap();
    test_edge_events();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
